// File: rtl/rf_writeback_queue.sv
// Write-side driver for the integer register file: merges single-cycle ALU results with
// buffered memory results onto one registered write port and flags RAW hazards for decode.
module rf_writeback_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_hold,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  input  logic [4:0]               dec_rs1,
  input  logic [4:0]               dec_rs2,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [4:0]      fifo_rd_d   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_data_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            full, push, push_store, alu_take, pop;
  logic            hit1, hit2, occ;
  logic [AW-1:0]   offs;

  assign full       = (count_q == FULL_CNT);
  assign mem_ready  = ~rst & ~full;
  assign alu_hold   = full;
  assign push       = mem_valid & mem_ready;
  assign push_store = push & (mem_rd != 5'd0);
  assign alu_take   = alu_valid & (alu_rd != 5'd0);
  // A live ALU write always wins the port, even when the FIFO is full.
  assign pop        = ~alu_take & (count_q != '0);

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_wdata_d  = rf_wdata_q;
    if (alu_take) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end
    if (push_store) begin
      fifo_rd_d[wr_ptr_q]   = mem_rd;
      fifo_data_d[wr_ptr_q] = mem_data;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_store) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    hit1 = rf_we_q & (rf_rd_q == dec_rs1);
    hit2 = rf_we_q & (rf_rd_q == dec_rs2);
    offs = '0;
    occ  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr_q;
      occ  = ({1'b0, offs} < count_q);
      hit1 = hit1 | (occ & (fifo_rd_q[i] == dec_rs1));
      hit2 = hit2 | (occ & (fifo_rd_q[i] == dec_rs2));
    end
  end

  assign stall      = ((dec_rs1 != 5'd0) & hit1) | ((dec_rs2 != 5'd0) & hit2);
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the write port.
module tb_rf_writeback_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_hold;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic            stall;
  logic [2:0]      fifo_count;

  always #5 clk = ~clk;

  rf_writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .stall(stall), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wdata;
  int              pass_cnt = 0;
  int              total_cnt = 0;
  int              cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  function automatic logic m_hit(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (m_we && m_rd == rs) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic av, input logic [4:0] ard,
                      input logic [XLEN-1:0] ad, input logic mv, input logic [4:0] mrd,
                      input logic [XLEN-1:0] md, input logic [4:0] rs1, input logic [4:0] rs2);
    logic mr;
    ent_t head;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; dec_rs1 = rs1; dec_rs2 = rs2;
    #1;
    mr = !r && (mq.size() < DEPTH);
    chk("mem_ready", mem_ready, mr);
    chk("alu_hold", alu_hold, mq.size() == DEPTH);
    chk("stall", stall, m_hit(rs1) || m_hit(rs2));
    if (r) begin
      mq.delete();
      m_we = 1'b0; m_rd = '0; m_wdata = '0;
    end else begin
      if (av && ard != 5'd0) begin
        m_we = 1'b1; m_rd = ard; m_wdata = ad;
      end else if (mq.size() > 0) begin
        head = mq.pop_front();
        m_we = 1'b1; m_rd = head.rd; m_wdata = head.data;
      end else begin
        m_we = 1'b0;
      end
      if (mv && mr && mrd != 5'd0) mq.push_back({mrd, md});
    end
    @(posedge clk); #1;
    cyc++;
    chk("rf_we", rf_we, m_we);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("fifo_count", fifo_count, mq.size());
  endtask

  task automatic idle(input logic [4:0] rs1);
    step(0, 0, 0, 0, 0, 0, 0, rs1, 0);
  endtask

  initial begin
    logic            r, av, mv;
    logic [4:0]      ard, mrd, rs1, rs2;
    logic [XLEN-1:0] ad, md;

    // reset with unknown inputs
    rst = 1'b1;
    alu_valid = 'x; alu_rd = 'x; alu_data = 'x;
    mem_valid = 'x; mem_rd = 'x; mem_data = 'x; dec_rs1 = 'x; dec_rs2 = 'x;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", mem_ready, 0);
    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0; dec_rs1 = 0; dec_rs2 = 0;
    #1;
    chk("ready_after_rst", mem_ready, 1);
    m_we = 1'b0; m_rd = '0; m_wdata = '0;

    // single ALU write
    step(0, 1, 5, 64'h1234, 0, 0, 0, 0, 0);
    chk("t2_we", rf_we, 1);
    chk("t2_rd", rf_rd, 5);
    chk("t2_wdata", rf_wdata, 64'h1234);
    idle(0);
    chk("t2_we_drop", rf_we, 0);

    // fill the FIFO behind a continuous ALU stream, then drain in order
    for (int i = 1; i <= 4; i++)
      step(0, 1, 9, 64'h900 + i, 1, 5'(i), 64'hA0 + i, 0, 0);
    chk("t3_full_ready", mem_ready, 0);
    chk("t3_full_hold", alu_hold, 1);
    for (int i = 1; i <= 4; i++) begin
      idle(0);
      chk("t3_drain_rd", rf_rd, i);
      chk("t3_drain_data", rf_wdata, 64'hA0 + i);
    end
    idle(0);
    chk("t3_drained", rf_we, 0);

    // push and pop in the same cycle at count 2
    step(0, 1, 9, 64'h1, 1, 10, 64'hB10, 0, 0);
    step(0, 1, 9, 64'h2, 1, 11, 64'hB11, 0, 0);
    step(0, 0, 0, 0, 1, 7, 64'hB07, 0, 0);
    chk("t4_count", fifo_count, 2);
    chk("t4_pop_rd", rf_rd, 10);
    idle(0);
    chk("t4_rd11", rf_rd, 11);
    idle(0);
    chk("t4_rd7", rf_rd, 7);
    idle(0);

    // hazard on a queued destination
    step(0, 1, 9, 64'h3, 1, 3, 64'hC3, 0, 0);
    idle(3);
    chk("t5_stall_rf", stall, 1);
    idle(3);
    chk("t5_stall_clear", stall, 0);
    step(0, 0, 0, 0, 1, 0, 64'hDEAD, 0, 0);
    chk("t5_x0_count", fifo_count, 0);

    // reset while entries are queued
    for (int i = 0; i < 3; i++)
      step(0, 1, 9, 64'h4, 1, 5'(21 + i), 64'hE0 + i, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 21, 22);
    chk("t6_count", fifo_count, 0);
    chk("t6_stall", stall, 0);
    for (int i = 0; i < 4; i++) begin
      idle(21);
      chk("t6_no_write", rf_we, 0);
    end

    // random traffic
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      av  = (mq.size() == DEPTH) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      ard = 5'($urandom_range(0, 7));
      ad  = {$urandom, $urandom};
      mv  = ($urandom_range(0, 9) < 6);
      mrd = 5'($urandom_range(0, 7));
      md  = {$urandom, $urandom};
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      step(r, av, ard, ad, mv, mrd, md, rs1, rs2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
